// File: rtl/program_loader.sv
// Receives a framed program stream (header count, N words, XOR checksum), writes the
// words into CPU program RAM, and releases the CPU with PC_Enable once the frame verifies.
module program_loader #(
    parameter int DATA_W = 11,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              RAM_Write_Enable,
    output logic [ADDR_W-1:0] RAM_Write_Address,
    output logic [DATA_W-1:0] RAM_Write_Data,
    output logic              PC_Enable,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                pc_en_q, pc_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                accept;
    logic [ADDR_W:0]     hdr_cnt;
    logic [ADDR_W:0]     last_addr;

    assign in_ready  = (state_q == S_HEADER) || (state_q == S_LOAD) || (state_q == S_CHECK);
    assign accept    = in_valid && in_ready;
    assign hdr_cnt   = in_data[ADDR_W:0];
    assign last_addr = cnt_q - CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_HEADER;
            end
            S_HEADER: begin
                if (accept) begin
                    cnt_d = hdr_cnt;
                    if ((hdr_cnt == '0) || (hdr_cnt > DEPTH_C)) begin
                        state_d = S_ERROR;
                    end else begin
                        addr_d  = '0;
                        csum_d  = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    csum_d  = csum_q ^ in_data;
                    addr_d  = addr_q + ADDR_ONE;
                    if ({1'b0, addr_q} == last_addr) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (accept) state_d = (in_data == csum_q) ? S_RUN : S_ERROR;
            end
            S_RUN, S_ERROR: begin
                if (start) state_d = S_HEADER;
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered from the next state so they line up with state_q.
        pc_en_d = (state_d == S_RUN);
        done_d  = (state_d == S_RUN);
        error_d = (state_d == S_ERROR);
        busy_d  = (state_d == S_HEADER) || (state_d == S_LOAD) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            pc_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            pc_en_q <= pc_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign RAM_Write_Enable  = we_q;
    assign RAM_Write_Address = waddr_q;
    assign RAM_Write_Data    = wdata_q;
    assign PC_Enable         = pc_en_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected RAM writes are queued as beats are issued
// and a negedge monitor pops them; frame outcome comes from a plain-arithmetic frame model.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [10:0] in_data;
    logic        in_ready;
    logic        RAM_Write_Enable;
    logic [2:0]  RAM_Write_Address;
    logic [10:0] RAM_Write_Data;
    logic        PC_Enable;
    logic        busy;
    logic        done;
    logic        error;

    typedef struct {
        logic [2:0]  addr;
        logic [10:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks;
    int          failures;
    logic [10:0] frame_words[8];

    program_loader #(.DATA_W(11), .ADDR_W(3), .DEPTH(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .RAM_Write_Enable  (RAM_Write_Enable),
        .RAM_Write_Address (RAM_Write_Address),
        .RAM_Write_Data    (RAM_Write_Data),
        .PC_Enable         (PC_Enable),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (RAM_Write_Enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write actual addr=%0d data=0x%0h expected no write",
                         RAM_Write_Address, RAM_Write_Data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (RAM_Write_Address !== e.addr || RAM_Write_Data !== e.data) begin
                    failures++;
                    $display("[TB] FAIL ram_write actual (%0d,0x%0h) expected (%0d,0x%0h)",
                             RAM_Write_Address, RAM_Write_Data, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_status(input string tag, input logic pc, input logic dn,
                                input logic er, input logic bz);
        checkOutput({tag, "_pc_enable"}, 32'(PC_Enable), 32'(pc));
        checkOutput({tag, "_done"},      32'(done),      32'(dn));
        checkOutput({tag, "_error"},     32'(error),     32'(er));
        checkOutput({tag, "_busy"},      32'(busy),      32'(bz));
    endtask

    // Present one beat from a negedge and hold it until accepted; returns on the next negedge.
    task automatic applyStimulus(input logic [10:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 16 && !ok; t++) begin
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL beat_accept actual=not_ready expected=accepted data=0x%0h", d);
        end
    endtask

    task automatic idle_cycles(input int k, input bit poke_start);
        for (int i = 0; i < k; i++) begin
            in_valid = 1'b0;
            in_data  = 11'($urandom);
            start    = poke_start && ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Frame model: legal count 1..8 gives count writes at ascending addresses, then RUN when
    // the checksum equals the XOR of the words, else ERROR; an illegal count is an immediate ERROR.
    task automatic run_frame(input logic [10:0] hdr, input logic [10:0] csum,
                             input int gap_mode, input bit do_start, input string tag);
        int          n;
        logic [10:0] x;
        wr_t         w;
        n = int'(hdr[3:0]);
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #2;
            check_status({tag, "_after_start"}, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(hdr);
        if (n < 1 || n > 8) begin
            #2;
            check_status({tag, "_bad_header"}, 1'b0, 1'b0, 1'b1, 1'b0);
            return;
        end
        x = '0;
        for (int i = 0; i < n; i++) begin
            if (gap_mode == 1) idle_cycles(1, 1'b0);
            if (gap_mode == 2) idle_cycles($urandom_range(0, 2), 1'b1);
            w.addr = 3'(i);
            w.data = frame_words[i];
            exp_q.push_back(w);
            x ^= frame_words[i];
            applyStimulus(frame_words[i]);
        end
        if (gap_mode == 1) idle_cycles(1, 1'b0);
        if (gap_mode == 2) idle_cycles($urandom_range(0, 2), 1'b1);
        applyStimulus(csum);
        #2;
        if (csum == x) check_status({tag, "_run"}, 1'b1, 1'b1, 1'b0, 1'b0);
        else           check_status({tag, "_err"}, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [10:0] hdr;
        logic [10:0] x;
        wr_t         w;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        #2;
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_write_en", 32'(RAM_Write_Enable), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed frame with known checksum, then the same frame with a wrong checksum.
        frame_words[0] = 11'h7A3;
        frame_words[1] = 11'h2B0;
        frame_words[2] = 11'h408;
        run_frame(11'd3, 11'h11B, 0, 1'b1, "t1");
        idle_cycles(3, 1'b0);
        check_status("t1_hold", 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(11'd3, 11'h11A, 0, 1'b1, "t2");

        run_frame(11'd0, 11'h000, 0, 1'b1, "t3_hdr0");
        run_frame(11'd9, 11'h000, 0, 1'b1, "t3_hdr9");

        // Full-depth frame with in_valid toggling every other cycle.
        x = '0;
        for (int i = 0; i < 8; i++) begin
            frame_words[i] = 11'($urandom);
            x ^= frame_words[i];
        end
        run_frame(11'd8, x, 1, 1'b1, "t4");

        // Start in RUN restarts; a one-word frame reloads.
        frame_words[0] = 11'h055;
        run_frame(11'd1, 11'h055, 0, 1'b1, "t6");

        // Reset after the second LOAD word is accepted.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        applyStimulus(11'd4);
        for (int i = 0; i < 2; i++) begin
            w.addr = 3'(i);
            w.data = 11'($urandom);
            exp_q.push_back(w);
            applyStimulus(w.data);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_status("t5_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t5_write_addr", 32'(RAM_Write_Address), 32'd0);
        checkOutput("t5_write_data", 32'(RAM_Write_Data), 32'd0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 11'($urandom);
            #1;
            checkOutput("t5_idle_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        checkOutput("t5_no_writes", 32'(exp_q.size()), 32'd0);

        // start together with in_valid in IDLE: the beat must not be taken as the header.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 11'd3;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        frame_words[0] = 11'h1C4;
        frame_words[1] = 11'h03F;
        run_frame(11'd2, 11'h1C4 ^ 11'h03F, 0, 1'b0, "t7");

        // Randomized frames with random gaps and ignored mid-frame start pulses.
        for (int f = 0; f < 14; f++) begin
            if ($urandom_range(0, 3) == 0) hdr = 11'($urandom);
            else hdr = {7'($urandom), 4'($urandom_range(1, 8))};
            x = '0;
            for (int i = 0; i < 8; i++) begin
                frame_words[i] = 11'($urandom);
                if (i < int'(hdr[3:0])) x ^= frame_words[i];
            end
            if ($urandom_range(0, 3) == 0) x ^= 11'($urandom_range(1, 2047));
            run_frame(hdr, x, 2, 1'b1, "rnd");
            idle_cycles($urandom_range(0, 3), 1'b0);
        end

        idle_cycles(2, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
